frame_pattern_checker: RTL and testbench

Self-check sink that drains the 17-bit LCD pixel queue fed by the colour-bar debug pattern path and verifies each frame against the expected bar pattern.
- Tracks frame sync, row and column position, and per-pixel colour.
- Reports per-frame pass/fail, error counters and a frame counter for on-board LEDs, UART debug and simulation benches.
- Sits directly downstream of the pixel queue, in place of the LCD driver.

---
 rtl/frame_pattern_checker_pkg.sv | 44 ++++
 rtl/frame_pattern_checker_if.sv | 19 +
 rtl/frame_pattern_checker_position_counter.sv | 81 ++++++++
 rtl/frame_pattern_checker.sv | 165 ++++++++++++++++
 tb/tb_frame_pattern_checker.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/frame_pattern_checker_pkg.sv
// ============================================================================
// pattern_pkg: shared pixel word type, checker states and colour-bar palette.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pattern_pkg;

  localparam int MAX_COLOR_BARS = 16;

  typedef struct packed {
    logic        sof;
    logic [15:0] rgb;
  } pixel_word_t;

  typedef enum logic [1:0] {
    ST_WAIT_SOF   = 2'd0,
    ST_CHECK      = 2'd1,
    ST_DONE       = 2'd2,
    ST_EXPECT_SOF = 2'd3
  } state_t;

  // RGB565 colour of vertical bar idx, left to right.
  function automatic logic [15:0] bar_color(input logic [3:0] idx);
    logic [15:0] c;
    case (idx)
      4'd0:    c = 16'hFFFF;
      4'd1:    c = 16'hFFE0;
      4'd2:    c = 16'h07FF;
      4'd3:    c = 16'h07E0;
      4'd4:    c = 16'hF81F;
      4'd5:    c = 16'hF800;
      4'd6:    c = 16'h001F;
      4'd7:    c = 16'h0000;
      4'd8:    c = 16'h8410;
      4'd9:    c = 16'hFD20;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_pattern_checker_if.sv
// ============================================================================
// frame_pattern_checker_if: standard-mode pixel queue read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface frame_pattern_checker_if;
  import pattern_pkg::*;

  pixel_word_t queue_data;
  logic        queue_empty;
  logic        queue_rd_en;

  modport master (output queue_data, output queue_empty, input  queue_rd_en);
  modport slave  (input  queue_data, input  queue_empty, output queue_rd_en);

endinterface

`default_nettype wire

// File: rtl/frame_pattern_checker_position_counter.sv
// ============================================================================
// pattern_position_counter: bar_col -> bar -> col -> row position chain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pattern_position_counter #(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int NUM_COLOR_BARS = 10
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic       advance_i,
  input  wire logic       restart_i,
  output logic [3:0]      bar_o,
  output logic            at_origin_o,
  output logic            last_pixel_o
);

  localparam int COL_W = $clog2(FRAME_WIDTH);
  localparam int ROW_W = $clog2(FRAME_HEIGHT);
  localparam int BAR_W = FRAME_WIDTH / NUM_COLOR_BARS;
  localparam int BC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [BC_W-1:0]  bar_col_q, bar_col_d, w_base_bc;
  logic [3:0]       bar_q, bar_d, w_base_bar;
  logic [COL_W-1:0] col_q, col_d, w_base_col;
  logic [ROW_W-1:0] row_q, row_d, w_base_row;

  // Restart makes the current word pixel (0,0) regardless of the stored position.
  assign w_base_bc  = restart_i ? '0 : bar_col_q;
  assign w_base_bar = restart_i ? '0 : bar_q;
  assign w_base_col = restart_i ? '0 : col_q;
  assign w_base_row = restart_i ? '0 : row_q;

  assign bar_o        = w_base_bar;
  assign at_origin_o  = (row_q == '0) && (col_q == '0);
  assign last_pixel_o = (w_base_row == ROW_W'(FRAME_HEIGHT - 1)) &&
                        (w_base_col == COL_W'(FRAME_WIDTH - 1));

  always_comb begin
    bar_col_d = w_base_bc;
    bar_d     = w_base_bar;
    col_d     = w_base_col;
    row_d     = w_base_row;
    if (advance_i) begin
      if (w_base_col == COL_W'(FRAME_WIDTH - 1)) begin
        col_d     = '0;
        bar_d     = '0;
        bar_col_d = '0;
        row_d     = (w_base_row == ROW_W'(FRAME_HEIGHT - 1)) ? '0 : w_base_row + 1'b1;
      end else begin
        col_d = w_base_col + 1'b1;
        if (w_base_bc == BC_W'(BAR_W - 1)) begin
          bar_col_d = '0;
          bar_d     = w_base_bar + 1'b1;
        end else begin
          bar_col_d = w_base_bc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_col_q <= '0;
      bar_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      bar_col_q <= bar_col_d;
      bar_q     <= bar_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_pattern_checker.sv
// ============================================================================
// frame_pattern_checker: drains the pixel queue and checks colour-bar frames.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_pattern_checker
  import pattern_pkg::*;
#(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int NUM_COLOR_BARS = 10
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              enable,
  frame_pattern_checker_if.slave q_if,
  output logic                   frame_done,
  output logic                   frame_ok,
  output logic [19:0]            pixel_errors,
  output logic [15:0]            sync_errors,
  output logic [15:0]            frames_checked
);

  if ((FRAME_WIDTH % NUM_COLOR_BARS) != 0) begin : g_width_check
    $fatal(1, "FRAME_WIDTH must be a multiple of NUM_COLOR_BARS");
  end
  if ((NUM_COLOR_BARS < 1) || (NUM_COLOR_BARS > MAX_COLOR_BARS)) begin : g_bars_check
    $fatal(1, "NUM_COLOR_BARS out of range");
  end

  state_t      state_q, state_d;
  logic        word_valid_q, word_valid_d;
  logic        hold_q;
  pixel_word_t held_q;
  pixel_word_t w_word;
  logic        frame_bad_q, frame_bad_d;
  logic        frame_ok_q, frame_ok_d;
  logic [19:0] pix_err_q, pix_err_d;
  logic [15:0] sync_err_q, sync_err_d;
  logic [15:0] frames_q, frames_d;

  logic        w_take, w_restart, w_mismatch, w_bad;
  logic        w_pix_inc, w_sync_inc;
  logic [3:0]  w_bar;
  logic        w_at_origin, w_last;

  assign q_if.queue_rd_en = enable && !q_if.queue_empty && (state_q != ST_DONE);

  // A word landing during DONE is kept and consumed in the following cycle.
  assign word_valid_d = q_if.queue_rd_en || (word_valid_q && (state_q == ST_DONE));
  assign w_word       = hold_q ? held_q : q_if.queue_data;

  pattern_position_counter #(
    .FRAME_WIDTH    (FRAME_WIDTH),
    .FRAME_HEIGHT   (FRAME_HEIGHT),
    .NUM_COLOR_BARS (NUM_COLOR_BARS)
  ) u_pos (
    .clk          (clk),
    .reset_n      (reset_n),
    .advance_i    (w_take),
    .restart_i    (w_restart),
    .bar_o        (w_bar),
    .at_origin_o  (w_at_origin),
    .last_pixel_o (w_last)
  );

  always_comb begin
    state_d     = state_q;
    w_take      = 1'b0;
    w_restart   = 1'b0;
    w_sync_inc  = 1'b0;
    w_pix_inc   = 1'b0;
    w_mismatch  = 1'b0;
    w_bad       = frame_bad_q;
    frame_bad_d = frame_bad_q;
    frame_ok_d  = frame_ok_q;
    frames_d    = frames_q;

    case (state_q)
      ST_WAIT_SOF: begin
        if (word_valid_q && w_word.sof) begin
          w_take    = 1'b1;
          w_restart = 1'b1;
        end
      end
      ST_CHECK: begin
        if (word_valid_q) begin
          w_take = 1'b1;
          if (w_word.sof && !w_at_origin) begin
            w_restart  = 1'b1;
            w_sync_inc = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_EXPECT_SOF;
      end
      ST_EXPECT_SOF: begin
        if (word_valid_q) begin
          if (w_word.sof) begin
            w_take    = 1'b1;
            w_restart = 1'b1;
          end else begin
            w_sync_inc = 1'b1;
            state_d    = ST_WAIT_SOF;
          end
        end
      end
      default: state_d = ST_WAIT_SOF;
    endcase

    if (w_take) begin
      w_mismatch  = (w_word.rgb != bar_color(w_bar));
      w_bad       = (frame_bad_q && !w_restart) || w_mismatch;
      frame_bad_d = w_bad;
      w_pix_inc   = w_mismatch;
      if (w_last) begin
        state_d    = ST_DONE;
        frame_ok_d = !w_bad;
        frames_d   = frames_q + 16'd1;
      end else begin
        state_d = ST_CHECK;
      end
    end
  end

  assign pix_err_d  = (w_pix_inc  && (pix_err_q  != '1)) ? pix_err_q  + 20'd1 : pix_err_q;
  assign sync_err_d = (w_sync_inc && (sync_err_q != '1)) ? sync_err_q + 16'd1 : sync_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT_SOF;
      word_valid_q <= 1'b0;
      hold_q       <= 1'b0;
      held_q       <= '0;
      frame_bad_q  <= 1'b0;
      frame_ok_q   <= 1'b0;
      pix_err_q    <= '0;
      sync_err_q   <= '0;
      frames_q     <= '0;
    end else begin
      state_q      <= state_d;
      word_valid_q <= word_valid_d;
      hold_q       <= word_valid_q && (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        held_q <= q_if.queue_data;
      end
      frame_bad_q  <= frame_bad_d;
      frame_ok_q   <= frame_ok_d;
      pix_err_q    <= pix_err_d;
      sync_err_q   <= sync_err_d;
      frames_q     <= frames_d;
    end
  end

  assign frame_done     = (state_q == ST_DONE);
  assign frame_ok       = frame_ok_q;
  assign pixel_errors   = pix_err_q;
  assign sync_errors    = sync_err_q;
  assign frames_checked = frames_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_pattern_checker.sv
// ============================================================================
// tb_frame_pattern_checker: FIFO model + scoreboard bench, 20x4 frame, 10 bars.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_pattern_checker;

  localparam int W  = 20;
  localparam int H  = 4;
  localparam int NB = 10;
  localparam int BW = W / NB;

  typedef struct packed {
    logic        ok;
    logic [15:0] frames;
    logic [19:0] pix;
    logic [15:0] sync;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_done;
  logic        frame_ok;
  logic [19:0] pixel_errors;
  logic [15:0] sync_errors;
  logic [15:0] frames_checked;

  frame_pattern_checker_if q_if();

  frame_pattern_checker #(
    .FRAME_WIDTH    (W),
    .FRAME_HEIGHT   (H),
    .NUM_COLOR_BARS (NB)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .q_if           (q_if.slave),
    .frame_done     (frame_done),
    .frame_ok       (frame_ok),
    .pixel_errors   (pixel_errors),
    .sync_errors    (sync_errors),
    .frames_checked (frames_checked)
  );

  always #5 clk = ~clk;

  logic [15:0] bars [NB] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F,
                             16'hF800, 16'h001F, 16'h0000, 16'h8410, 16'hFD20};

  logic [16:0] fifo[$];
  res_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  bit          jitter = 1'b0;
  bit          en_r = 1'b1;
  int          cyc = 0;
  logic        rd_s;
  bit          force_e;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  task automatic push_word(input bit sof, input logic [15:0] rgb);
    fifo.push_back({sof, rgb});
  endtask

  task automatic push_range(input int lo, input int hi, input int bad_idx, input logic [15:0] bad_val);
    for (int i = lo; i <= hi; i++)
      push_word(i == 0, (i == bad_idx) ? bad_val : bars[(i % W) / BW]);
  endtask

  task automatic expect_frame(input bit ok, input int frames, input int pix, input int sync);
    res_t r;
    r.ok     = ok;
    r.frames = 16'(frames);
    r.pix    = 20'(pix);
    r.sync   = 16'(sync);
    exp_q.push_back(r);
  endtask

  // FIFO model: read strobe sampled just before the edge, data appears after it.
  initial begin
    q_if.queue_data  = '0;
    q_if.queue_empty = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (jitter) begin
        if ((cyc % 7) == 0) en_r = !en_r;
        enable  = en_r;
        force_e = ($urandom_range(0, 3) == 0);
      end else begin
        enable  = 1'b1;
        force_e = 1'b0;
      end
      q_if.queue_empty = (fifo.size() == 0) || force_e;
      #4;
      rd_s = q_if.queue_rd_en;
      @(posedge clk);
      #1;
      if (rd_s && (fifo.size() > 0)) q_if.queue_data = fifo.pop_front();
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (reset_n && frame_done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_frame_done: got frame_done=1, expected none");
      end else begin
        r = exp_q.pop_front();
        chk("frame_ok",       32'(frame_ok),       32'(r.ok));
        chk("frames_checked", 32'(frames_checked), 32'(r.frames));
        chk("pixel_errors",   32'(pixel_errors),   32'(r.pix));
        chk("sync_errors",    32'(sync_errors),    32'(r.sync));
      end
    end
  end

  task automatic do_reset();
    fifo.delete();
    jitter = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_frame_done",     32'(frame_done),     32'd0);
    chk("rst_frame_ok",       32'(frame_ok),       32'd0);
    chk("rst_pixel_errors",   32'(pixel_errors),   32'd0);
    chk("rst_sync_errors",    32'(sync_errors),    32'd0);
    chk("rst_frames_checked", 32'(frames_checked), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    while (((fifo.size() != 0) || (exp_q.size() != 0)) && (t < 3000)) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk("frames_reported", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    do_reset();

    // one clean frame
    push_range(0, W*H-1, -1, 16'h0);
    expect_frame(1, 1, 0, 0);
    drain();
    chk("t1_frame_ok_held", 32'(frame_ok), 32'd1);
    chk("t1_frames",        32'(frames_checked), 32'd1);

    // bad pixel at (2,5), then a clean frame back to back
    push_range(0, W*H-1, 2*W+5, 16'h1234);
    expect_frame(0, 2, 1, 0);
    push_range(0, W*H-1, -1, 16'h0);
    expect_frame(1, 3, 1, 0);
    drain();
    chk("t2_pixel_errors", 32'(pixel_errors), 32'd1);

    // leading garbage without SOF is ignored
    do_reset();
    push_word(1'b0, 16'hFFFF);
    push_word(1'b0, 16'h1234);
    push_word(1'b0, 16'h0000);
    push_range(0, W*H-1, -1, 16'h0);
    expect_frame(1, 1, 0, 0);
    drain();
    chk("t3_sync_errors", 32'(sync_errors), 32'd0);

    // early SOF at word 50 restarts the frame
    do_reset();
    push_range(0, 49, -1, 16'h0);
    push_range(0, W*H-1, -1, 16'h0);
    expect_frame(1, 1, 0, 1);
    drain();
    chk("t4_sync_errors", 32'(sync_errors), 32'd1);

    // early SOF carrying a wrong colour counts as both errors
    do_reset();
    push_range(0, 29, -1, 16'h0);
    push_word(1'b1, 16'h1234);
    push_range(1, W*H-1, -1, 16'h0);
    expect_frame(0, 1, 1, 1);
    drain();

    // non-SOF word right after a frame
    do_reset();
    push_range(0, W*H-1, -1, 16'h0);
    expect_frame(1, 1, 0, 0);
    push_word(1'b0, 16'hFFFF);
    push_range(0, W*H-1, -1, 16'h0);
    expect_frame(1, 2, 0, 1);
    drain();
    chk("t5_sync_errors", 32'(sync_errors), 32'd1);

    // enable / empty jitter, then reset in the middle of a frame
    do_reset();
    jitter = 1'b1;
    push_range(0, W*H-1, -1, 16'h0);
    expect_frame(1, 1, 0, 0);
    drain();
    jitter = 1'b0;
    push_range(0, 39, -1, 16'h0);
    for (int t = 0; (t < 500) && (fifo.size() != 0); t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t6_partial_no_extra_frame", 32'(frames_checked), 32'd1);
    do_reset();
    push_range(0, W*H-1, -1, 16'h0);
    expect_frame(1, 1, 0, 0);
    drain();
    chk("t6_final_pixel_errors", 32'(pixel_errors), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
